reg_serializer: RTL

REG_SERIALIZER -- requirements
Module: reg_serializer

---
 rtl/reg_serializer.sv | 83 ++++++++
 1 files changed

// File: rtl/reg_serializer.sv
// Parallel-to-serial converter with valid/ready handshakes on both sides.
// A captured word is shifted out one bit per accepted transfer, then a
// one-cycle DONE state pulses done before the block accepts another word.
module reg_serializer #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         busy,
  output logic         done
);

  // Counter must reach N-1; N=1 still needs a 1-bit register.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic           load_fire, bit_fire;

  assign load_fire = load_valid & load_ready;
  assign bit_fire  = ser_valid & ser_ready;

  // State register; reset forces IDLE immediately so outputs follow without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore outputs; ser_ready only matters in SHIFT.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ser_out    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = LSB_FIRST ? sreg[0] : sreg[N-1];
        if (ser_ready && cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; both hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load_fire) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (bit_fire) begin
      sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
      // Parks at N-1 on the final bit instead of wrapping.
      if (cnt != LAST) cnt <= cnt + CW'(1);
    end
  end

endmodule
